// File: rtl/mmio_data_queue_if.sv
// Handshake bundle between MMIO decode/response logic and the data queue.
// Producers/consumers hold the master side; the queue holds the slave side.
interface mmio_data_queue_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic             flush;
   logic             clr_err;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic [63:0]      status;

   modport master (
      output wr_en, wr_data, rd_req, flush, clr_err,
      input  rd_valid, rd_data, count, full, empty, status
   );

   modport slave (
      input  wr_en, wr_data, rd_req, flush, clr_err,
      output rd_valid, rd_data, count, full, empty, status
   );
endinterface

// File: rtl/mmio_data_queue.sv
// Circular-buffer queue: MMIO writes push 64-bit words, MMIO reads pop them
// with one-cycle latency; every read is answered, with 0 on underflow.
module mmio_data_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input logic              clk,
   input logic              rst,
   mmio_data_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [CW-1:0]    cnt;
   logic             ovf, udf;
   logic             rd_valid_q;
   logic [WIDTH-1:0] rd_data_q;

   logic is_full, is_empty, do_pop, do_push, ovf_ev, udf_ev;

   always_comb begin
      is_full  = (cnt == CW'(DEPTH));
      is_empty = (cnt == '0);
      // A pop in the same cycle frees a slot, so a full queue still accepts the push.
      do_pop   = bus.rd_req & ~bus.flush & ~is_empty;
      do_push  = bus.wr_en & ~bus.flush & (~is_full | do_pop);
      ovf_ev   = bus.wr_en & ~bus.flush & is_full & ~do_pop;
      udf_ev   = bus.rd_req & (bus.flush | is_empty);
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= bus.wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         udf        <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= bus.rd_req;
         if (do_pop)          rd_data_q <= mem[rp];
         else if (bus.rd_req) rd_data_q <= '0;

         if (bus.flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
         end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
         end

         // New error events win over a same-cycle clear.
         ovf <= ovf_ev | (ovf & ~bus.clr_err);
         udf <= udf_ev | (udf & ~bus.clr_err);
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.count    = cnt;
   assign bus.full     = is_full;
   assign bus.empty    = is_empty;
   assign bus.status   = {ovf, udf, 44'b0, is_full, is_empty, 16'(cnt)};
endmodule
